// File: rtl/fifo_stream_reader.sv
// Drain-side adapter: pops a block-RAM FIFO with one-cycle read latency
// and re-times the words into a valid/ready stream with frame markers.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [CW-1:0]         beat_cnt;
  logic [2:0]            pend;
  logic                  pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one still coming back from the RAM.
  assign pend       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rst_n & ~fifo_empty & (pend < 3'd3);

  assign o_valid = (occ != 2'd0);
  assign pop     = o_valid & i_ready;
  assign o_data  = mem_q[rd_ptr];
  assign o_last  = o_valid & (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight)
        wr_ptr <= next_ptr(wr_ptr);
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);
      unique case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop)
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        mem_q[i] <= '0;
    end else if (inflight) begin
      mem_q[wr_ptr] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-backed FIFO model feeds the DUT
// and a scoreboard checks order, frame markers and stall behaviour.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int FL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          i_ready = 1'b0;

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .i_ready      (i_ready)
  );

  always #5 clk = ~clk;

  // Source FIFO: registered read data, one cycle after the strobe.
  logic [DW-1:0] mem [0:8191];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] seq = '0;
  int beats = 0;
  int outstanding = 0;
  int n_last = 0;
  int cyc = 0;
  bit stall_prev = 0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  bit s_rd_en, s_valid;

  typedef struct {
    bit          push;
    bit          rdy;
    bit          rd_en;
    bit          valid;
    bit          dchk;
    logic [31:0] data;
    bit          last;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic sample();
    logic [DW-1:0] e;
    s_rd_en = fifo_rd_en;
    s_valid = o_valid;
    if (rst_n) begin
      chk("no_underflow", {63'd0, fifo_rd_en & fifo_empty}, 64'd0);
      chk("pending_le3", 64'(outstanding + int'(fifo_rd_en) <= 3), 64'd1);
      if (stall_prev) begin
        chk("stall_data", 64'(o_data), 64'(prev_data));
        chk("stall_last", 64'(o_last), 64'(prev_last));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(o_data), 64'hffff_ffff_ffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(o_data), 64'(e));
        end
        chk("beat_last", 64'(o_last), 64'((beats % FL) == FL - 1));
        if (o_last) n_last++;
        beats++;
      end
      outstanding += int'(fifo_rd_en) - int'(o_valid && i_ready);
      stall_prev = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  endtask

  task automatic step(input bit rdy, input int npush);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < npush; i++) begin
      mem[wp] = seq;
      exp_q.push_back(seq);
      seq++;
      wp++;
    end
    i_ready = rdy;
    #1;
    sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_ready = 1'b0;
    wp = rp;
    for (int i = 0; i < 3; i++) begin
      mem[wp] = 32'hdead_0000 + i;
      wp++;
    end
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    wp = rp;
    exp_q.delete();
    beats = 0;
    outstanding = 0;
    stall_prev = 0;
    n_last = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(rnd ? bit'($urandom % 2) : 1'b1, 0);
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rd, t_v, gaps, late_rd, pushed, n;

    tbl[0] = '{1, 0, 1, 0, 1, 32'd0,   0};
    tbl[1] = '{0, 0, 0, 0, 1, 32'd0,   0};
    tbl[2] = '{1, 0, 1, 1, 1, 32'd100, 0};
    tbl[3] = '{1, 0, 1, 1, 1, 32'd100, 0};
    tbl[4] = '{1, 0, 0, 1, 1, 32'd100, 0};
    tbl[5] = '{0, 1, 0, 1, 1, 32'd100, 0};
    tbl[6] = '{0, 1, 1, 1, 1, 32'd101, 0};
    tbl[7] = '{0, 1, 0, 1, 1, 32'd102, 0};
    tbl[8] = '{0, 1, 0, 1, 1, 32'd103, 0};
    tbl[9] = '{0, 1, 0, 0, 0, 32'd0,   0};

    // Cycle-exact vectors from an idle buffer.
    do_reset();
    seq = 32'd100;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rdy, int'(tbl[i].push));
      chk($sformatf("tbl%0d_rd_en", i), 64'(fifo_rd_en), 64'(tbl[i].rd_en));
      chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].valid));
      if (tbl[i].dchk)
        chk($sformatf("tbl%0d_data", i), 64'(o_data), 64'(tbl[i].data));
      chk($sformatf("tbl%0d_last", i), 64'(o_last), 64'(tbl[i].last));
    end

    // Full-rate stream of 32 preloaded words.
    do_reset();
    seq = '0;
    t_rd = -1; t_v = -1; gaps = 0;
    step(1'b1, 32);
    if (s_rd_en) t_rd = cyc;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1'b1, 0);
      if (s_valid && t_v < 0) t_v = cyc;
      else if (!s_valid && t_v >= 0 && exp_q.size() != 0) gaps++;
      n++;
    end
    chk("full_latency", 64'(t_v - t_rd), 64'd2);
    chk("full_gaps", 64'(gaps), 64'd0);
    chk("full_lasts", 64'(n_last), 64'd2);
    chk("full_done", 64'(exp_q.size()), 64'd0);

    // Backpressure for 10 cycles mid-stream.
    do_reset();
    seq = 32'd200;
    step(1'b1, 20);
    repeat (6) step(1'b1, 0);
    late_rd = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 0);
      if (i >= 1 && s_rd_en) late_rd++;
    end
    chk("bp_buffered", 64'(outstanding), 64'd3);
    chk("bp_late_rd", 64'(late_rd), 64'd0);
    chk("bp_valid", 64'(s_valid), 64'd1);
    gaps = 0; n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step(1'b1, 0);
      if (!s_valid && exp_q.size() != 0) gaps++;
      n++;
    end
    chk("bp_gaps", 64'(gaps), 64'd0);
    chk("bp_done", 64'(exp_q.size()), 64'd0);

    // Underrun: FIFO empties, then refills.
    do_reset();
    seq = 32'd0;
    step(1'b1, 5);
    repeat (8) step(1'b1, 0);
    chk("ur_idle_valid", 64'(s_valid), 64'd0);
    chk("ur_first_done", 64'(exp_q.size()), 64'd0);
    step(1'b1, 5);
    t_rd = cyc; t_v = -1; n = 0;
    while (t_v < 0 && n < 20) begin
      step(1'b1, 0);
      if (s_valid) t_v = cyc;
      n++;
    end
    chk("ur_resume", 64'(t_v - t_rd), 64'd2);
    drain(40, 1'b0);

    // Reset in the middle of a frame.
    do_reset();
    seq = 32'd400;
    step(1'b1, 30);
    n = 0;
    while (beats < 8 && n < 60) begin
      step(1'b1, 0);
      n++;
    end
    chk("mf_beats", 64'(beats), 64'd8);
    do_reset();
    seq = 32'd500;
    step(1'b1, 16);
    drain(60, 1'b0);
    chk("mf_lasts", 64'(n_last), 64'd1);
    chk("mf_beats_post", 64'(beats), 64'd16);

    // Random soak.
    do_reset();
    seq = 32'd1000;
    pushed = 0;
    n = 0;
    while (pushed < 2000 && n < 20000) begin
      if (($urandom % 2) == 1) begin
        step(bit'($urandom % 2), 1);
        pushed++;
      end else begin
        step(bit'($urandom % 2), 0);
      end
      n++;
    end
    drain(20000, 1'b1);
    chk("soak_beats", 64'(beats), 64'd2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
